// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one signed Booth multiplier among NREQ requesters.
// Optional done watchdog is built when BOOTH_ARB_TIMEOUT_EN is defined.
module booth_mult_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned W         = 16,
    parameter int unsigned ID_W      = $clog2(NREQ),
    parameter int unsigned FLUSH_CYC = 64,
    parameter int unsigned TMO       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [W-1:0]      mul_m,
    output logic [W-1:0]      mul_q,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_prod
);
    localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [NREQ-1:0] gnt_d;
    logic            busy_d, start_d, valid_d, err_d;
    logic [ID_W-1:0] rsp_id_d;
    logic [2*W-1:0]  prod_d;
    logic [W-1:0]    m_d, q_d;
    logic            tmo_hit;
    logic            found;
    int unsigned     win, idx;
    logic [NREQ-1:0] sh;

    // Round-robin search: first set req bit at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = 0;
        idx   = 0;
        sh    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int unsigned TC_W = $clog2(TMO + 1);
    logic [TC_W-1:0] tcnt_q;

    // Watchdog counts WAIT cycles; cleared whenever outside WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tcnt_q <= '0;
        else if (state_q != S_WAIT) tcnt_q <= '0;
        else                        tcnt_q <= tcnt_q + TC_W'(1);
    end

    assign tmo_hit = (tcnt_q == TC_W'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        gnt_d    = '0;
        start_d  = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rsp_id_d = rsp_id;
        prod_d   = rsp_prod;
        m_d      = mul_m;
        q_d      = mul_q;
        case (state_q)
            S_FLUSH: begin
                if (fcnt_q == FC_W'(FLUSH_CYC - 1)) begin
                    fcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    fcnt_d = fcnt_q + FC_W'(1);
                end
            end
            S_IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << win;
                    start_d = 1'b1;
                    m_d     = W'(a_in >> (win * W));
                    q_d     = W'(b_in >> (win * W));
                    id_d    = ID_W'(win);
                    ptr_d   = ID_W'((win + 1) % NREQ);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    valid_d  = 1'b1;
                    prod_d   = mul_prod;
                    rsp_id_d = id_q;
                    state_d  = S_RESP;
                end else if (tmo_hit) begin
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    prod_d   = '0;
                    rsp_id_d = id_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                // A timed-out multiplier may still be running: resynchronise via flush.
                state_d = rsp_err ? S_FLUSH : S_IDLE;
            end
            default: state_d = S_FLUSH;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FLUSH;
            fcnt_q    <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            gnt       <= '0;
            busy      <= 1'b1;
            mul_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            mul_m     <= '0;
            mul_q     <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            mul_start <= start_d;
            rsp_valid <= valid_d;
            rsp_err   <= err_d;
            rsp_id    <= rsp_id_d;
            rsp_prod  <= prod_d;
            mul_m     <= m_d;
            mul_q     <= q_d;
        end
    end
endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one signed Booth multiplier among `NREQ` requesters. It captures the winning requester's operands and pulses the multiplier's start, waits for done, then returns the 2W-bit product tagged with the requester ID. It sits between the client blocks and the Booth multiplier (controller plus datapath). It also covers the multiplier having no reset of its own: a post-reset flush keeps a stale in-flight product from being delivered.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, range 2..16.
- `W`, 16: operand width. Product is 2W bits.
- `ID_W`, `$clog2(NREQ)`: width of the requester ID.
- `FLUSH_CYC`, 64: post-reset wait, in cycles. Must be at least the multiplier's worst-case start-to-done latency plus 2.
- `TMO`, 255: watchdog limit in cycles. Used only when `BOOTH_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, NREQ: request level, one bit per requester. A requester holds its bit until it sees its `gnt` bit.
- `a_in`, in, NREQ*W: multiplicand per requester. Slice i is bits [i*W +: W].
- `b_in`, in, NREQ*W: multiplier per requester, sliced the same way.
- `gnt`, out, NREQ: one-hot, one-cycle pulse. It means this requester's operands were captured.
- `busy`, out, 1: high in every state except IDLE.
- `rsp_valid`, out, 1: one-cycle pulse marking a valid response.
- `rsp_id`, out, ID_W: ID of the requester that owns the response.
- `rsp_prod`, out, 2W: signed product.
- `rsp_err`, out, 1: timeout flag, qualified by `rsp_valid`.
- `mul_start`, out, 1: one-cycle start pulse to the multiplier.
- `mul_m`, out, W: multiplicand to the multiplier. Held stable from the start pulse until done.
- `mul_q`, out, W: multiplier operand, held the same way.
- `mul_done`, in, 1: one-cycle done pulse from the multiplier.
- `mul_prod`, in, 2W: multiplier product, sampled in the `mul_done` cycle.

## Operation
States are FLUSH, IDLE, WAIT and RESP. All outputs are registered.

Reset:
- State goes to FLUSH. Round-robin pointer `ptr` = 0. Flush counter = 0.
- Every output is 0: `gnt`, `mul_start`, `rsp_valid`, `rsp_err`, `rsp_id`, `rsp_prod`, `mul_m`, `mul_q`.
- `busy` = 1 during FLUSH.

FLUSH:
- Counts `FLUSH_CYC` cycles. `req` and `mul_done` are ignored.
- At the terminal count, moves to IDLE.
- Reset asserted mid-operation abandons the transaction: no `rsp_valid` is issued, and the flush is re-entered.

IDLE:
- If `req` != 0, the winner i is the first set bit at or above `ptr`, wrapping modulo NREQ.
- On that edge the block registers:
  - `gnt[i]`=1, `mul_start`=1
  - `mul_m`=slice i of `a_in`, `mul_q`=slice i of `b_in`
  - captured ID = i
  - `ptr` = (i+1) mod NREQ
  - state = WAIT
- `req` = 0: the block stays in IDLE with all pulses low.

WAIT:
- `gnt` and `mul_start` are low.
- `mul_m` and `mul_q` are held unchanged.
- When `mul_done`=1: registers `rsp_prod`=`mul_prod`, `rsp_id`=captured ID, `rsp_err`=0, `rsp_valid`=1, then goes to RESP.

RESP:
- `rsp_valid` is high for this single cycle, then the block returns to IDLE.
- `rsp_prod` and `rsp_id` hold their values until the next response.

Boundary conditions:
- `mul_done` seen in IDLE or RESP is ignored.
- `req` bits that change while the block is busy take effect only at the next IDLE evaluation.
- Only one transaction is ever outstanding.
- A requester that drops `req` before its grant is never granted.
- A requester that keeps `req` high after its grant is arbitrated again as a new request.

## Timing
- `req` sampled in IDLE at edge t gives `gnt` and `mul_start` high during cycle t+1.
- `mul_done` high in cycle d gives `rsp_valid` high in cycle d+1.
- IDLE is re-entered at cycle d+2, so the earliest next grant is in cycle d+3.
- Arbiter overhead per transaction is 3 cycles on top of multiplier latency.
- Fairness: with all requesters continuously active, each is granted exactly once in every NREQ consecutive grants.

## Configuration
`BOOTH_ARB_TIMEOUT_EN`:
- Defined: a WAIT-state counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TMO` with no `mul_done`, the block registers `rsp_valid`=1, `rsp_err`=1, `rsp_prod`=0 and `rsp_id`=captured ID, then goes to RESP and on to FLUSH instead of IDLE.
  - This resynchronises with a multiplier that may still be running.
- Undefined: no counter is built, WAIT lasts until `mul_done`, and `rsp_err` is tied to 0.

## Test plan
- Single requester: after the flush, req[2]=1 with a=3, b=-5. Expect `gnt`=4'b0100 for one cycle, then `rsp_valid` with `rsp_id`=2 and `rsp_prod`=-15 (32-bit), one cycle after `mul_done`.
- All four requesters held high from reset, each with distinct operands. Expect grants in order 0,1,2,3,0, each product matching its own operands, and exactly one outstanding start.
- Wrap-around: grant requester 3, then assert req=4'b1001. Expect the next grant to go to requester 0, then requester 3.
- Reset mid-operation: assert `rst` during WAIT, then deassert. Expect no `rsp_valid`, `busy`=1 for 64 cycles, and a stale `mul_done` during the flush ignored. The next request completes correctly.
- Extremes: a=-32768, b=-32768 gives 1073741824; a=32767, b=-1 gives -32767; a=0, b=x gives 0.
- With `BOOTH_ARB_TIMEOUT_EN` and a stub that never asserts done: expect `rsp_valid` with `rsp_err`=1 and `rsp_prod`=0 after 255 WAIT cycles, followed by FLUSH and no further grants until the flush ends.
